alu_operand_stage: RTL and testbench

//  Upstream feeder of the ALU. Fetches 4-byte instructions (OPCODE, ARG1, ARG2, DEST) from byte-wide program memory.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_regfile.sv | 59 +++++
 rtl/alu_operand_stage.sv | 149 ++++++++++++++
 tb/tb_alu_operand_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand stage.
//   IMM1_BIT / IMM2_BIT : opcode bits that select immediate vs register operands
//   ALU_SEL_BIT         : opcode bit decoded by the ALU itself (not used here)
//   REG_IDX_W           : register index width
//   fetch_state_e       : instruction fetch / issue sequence
package alu_pkg;

   localparam int unsigned IMM1_BIT    = 7;
   localparam int unsigned IMM2_BIT    = 6;
   localparam int unsigned ALU_SEL_BIT = 5;
   localparam int unsigned REG_IDX_W   = 3;

   typedef enum logic [2:0] {
      F_OP,
      F_A1,
      F_A2,
      F_DST,
      ISSUE
   } fetch_state_e;

endpackage

// File: rtl/alu_regfile.sv
// General register file: NUM_REGS x 8 bits, two asynchronous read ports, one synchronous
// write port. Indices >= NUM_REGS read 8'h00 and ignore writes. Reset clears all registers.
// Optional feature macro: OPERAND_FWD_EN -- a write in the same cycle as a read of the same
// register returns the write data on the read port.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   we, waddr, wdata      write strobe, index, data
//   raddr1/2, rdata1/2    read indices and data
module alu_regfile
   import alu_pkg::*;
#(
   parameter int unsigned NUM_REGS = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 we,
   input  logic [REG_IDX_W-1:0] waddr,
   input  logic [7:0]           wdata,
   input  logic [REG_IDX_W-1:0] raddr1,
   input  logic [REG_IDX_W-1:0] raddr2,
   output logic [7:0]           rdata1,
   output logic [7:0]           rdata2
);

   localparam int unsigned MaxRegs = 1 << REG_IDX_W;

   logic [MaxRegs-1:0][7:0] regs;
   logic [MaxRegs-1:0]      reg_valid;
   logic                    wr_en;

   assign wr_en = we & reg_valid[waddr];

   for (genvar i = 0; i < MaxRegs; i++) begin : g_reg
      if (i < NUM_REGS) begin : g_impl
         logic [7:0] reg_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               reg_q <= 8'h00;
            end else if (wr_en && (waddr == REG_IDX_W'(i))) begin
               reg_q <= wdata;
            end
         end
         assign regs[i]      = reg_q;
         assign reg_valid[i] = 1'b1;
      end else begin : g_absent
         assign regs[i]      = 8'h00;
         assign reg_valid[i] = 1'b0;
      end
   end

`ifdef OPERAND_FWD_EN
   assign rdata1 = (wr_en && (waddr == raddr1)) ? wdata : regs[raddr1];
   assign rdata2 = (wr_en && (waddr == raddr2)) ? wdata : regs[raddr2];
`else
   assign rdata1 = regs[raddr1];
   assign rdata2 = regs[raddr2];
`endif

endmodule

// File: rtl/alu_operand_stage.sv
// ALU operand stage: fetches 4-byte instructions (OPCODE, ARG1, ARG2, DEST) from byte-wide
// program memory, resolves each argument to an immediate or register value and presents the
// result to the ALU through a valid/ready handshake. Owns the PC and the register file.
// Optional feature macro: OPERAND_FWD_EN (writeback-to-operand bypass in the capture cycle).
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   mem_req, mem_addr, mem_ack,
//   mem_rdata                        program-memory byte fetch
//   out_valid, out_ready, opcode,
//   input1, input2, dest             issue handshake and operands
//   wb_en, wb_addr, wb_data          register writeback
//   pc_load, pc_load_val             branch redirect (highest priority)
module alu_operand_stage
   import alu_pkg::*;
#(
   parameter int unsigned NUM_REGS = 6,
   parameter logic [7:0]  PC_RESET = 8'h00
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic                 mem_req,
   output logic [7:0]           mem_addr,
   input  logic                 mem_ack,
   input  logic [7:0]           mem_rdata,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [7:0]           opcode,
   output logic [7:0]           input1,
   output logic [7:0]           input2,
   output logic [7:0]           dest,
   input  logic                 wb_en,
   input  logic [REG_IDX_W-1:0] wb_addr,
   input  logic [7:0]           wb_data,
   input  logic                 pc_load,
   input  logic [7:0]           pc_load_val
);

   fetch_state_e state_q, state_d;
   logic [7:0]   pc_q, pc_d;
   logic [7:0]   op_q, arg1_q, arg2_q;
   logic [7:0]   opcode_q, input1_q, input2_q, dest_q;
   logic [7:0]   rd1, rd2;
   logic         fetching, fetch_ack, capture;

   assign fetching  = (state_q != ISSUE);
   // A redirect discards any byte acknowledged in the same cycle.
   assign fetch_ack = fetching & mem_ack & ~pc_load;
   assign capture   = fetch_ack & (state_q == F_DST);

   alu_regfile #(
      .NUM_REGS (NUM_REGS)
   ) u_regfile (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (wb_en),
      .waddr  (wb_addr),
      .wdata  (wb_data),
      .raddr1 (arg1_q[REG_IDX_W-1:0]),
      .raddr2 (arg2_q[REG_IDX_W-1:0]),
      .rdata1 (rd1),
      .rdata2 (rd2)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= F_OP;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (pc_load) begin
         state_d = F_OP;
      end else begin
         unique case (state_q)
            F_OP:    if (mem_ack) state_d = F_A1;
            F_A1:    if (mem_ack) state_d = F_A2;
            F_A2:    if (mem_ack) state_d = F_DST;
            F_DST:   if (mem_ack) state_d = ISSUE;
            ISSUE:   if (out_ready) state_d = F_OP;
            default: state_d = F_OP;
         endcase
      end
   end

   // Outputs; the request is held low while reset is asserted.
   always_comb begin
      mem_req   = fetching & rst_n;
      mem_addr  = pc_q;
      out_valid = (state_q == ISSUE);
      opcode    = opcode_q;
      input1    = input1_q;
      input2    = input2_q;
      dest      = dest_q;
   end

   always_comb begin
      pc_d = pc_q;
      if (pc_load) begin
         pc_d = pc_load_val;
      end else if (fetch_ack) begin
         pc_d = pc_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= PC_RESET;
      end else begin
         pc_q <= pc_d;
      end
   end

   // Instruction byte latches
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q   <= 8'h00;
         arg1_q <= 8'h00;
         arg2_q <= 8'h00;
      end else if (fetch_ack) begin
         case (state_q)
            F_OP:    op_q   <= mem_rdata;
            F_A1:    arg1_q <= mem_rdata;
            F_A2:    arg2_q <= mem_rdata;
            default: ;
         endcase
      end
   end

   // Operand capture on the DEST byte; held stable throughout ISSUE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opcode_q <= 8'h00;
         input1_q <= 8'h00;
         input2_q <= 8'h00;
         dest_q   <= 8'h00;
      end else if (capture) begin
         opcode_q <= op_q;
         input1_q <= op_q[IMM1_BIT] ? arg1_q : rd1;
         input2_q <= op_q[IMM2_BIT] ? arg2_q : rd2;
         dest_q   <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: randomized memory timing, writebacks, ready
// back-pressure and redirects against a behavioural instruction-level model. The driver
// pushes expected issues into a scoreboard; a monitor compares whenever out_valid is high.
module tb_alu_operand_stage;

   localparam int unsigned NR  = 6;
   localparam logic [7:0]  PCR = 8'h00;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       mem_req, mem_ack, out_valid, out_ready, wb_en, pc_load;
   logic [7:0] mem_addr, mem_rdata, opcode, input1, input2, dest, wb_data, pc_load_val;
   logic [2:0] wb_addr;

   always #5 clk = ~clk;

   alu_operand_stage #(
      .NUM_REGS (NR),
      .PC_RESET (PCR)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .opcode      (opcode),
      .input1      (input1),
      .input2      (input2),
      .dest        (dest),
      .wb_en       (wb_en),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .pc_load     (pc_load),
      .pc_load_val (pc_load_val)
   );

   typedef struct packed {
      logic [7:0] op;
      logic [7:0] in1;
      logic [7:0] in2;
      logic [7:0] dst;
   } exp_t;

   exp_t       sb[$];
   int         vectors = 0;
   int         miscompares = 0;
   logic [7:0] mem [256];

   // Instruction-level model
   logic [7:0] m_pc;
   int         m_cnt;          // bytes fetched of current instruction; 4 = awaiting transfer
   logic [7:0] m_bytes [4];
   logic [7:0] m_regs [8];
   bit         rst_done = 0;
   int         ack_pct, wb_pct, load_pct, rdy_pct;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc  = PCR;
      m_cnt = 0;
      for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
      sb.delete();
   endtask

   // Register read as seen at operand capture, given this cycle's writeback.
   function automatic logic [7:0] reg_read(input logic [7:0] arg, input bit wb,
                                           input logic [2:0] wa, input logic [7:0] wd);
      int idx;
      idx = int'(arg[2:0]);
      if (idx >= int'(NR)) return 8'h00;
`ifdef OPERAND_FWD_EN
      if (wb && int'(wa) == idx) return wd;
`endif
      return m_regs[idx];
   endfunction

   task automatic drive_idle();
      mem_ack     = 1'b0;
      mem_rdata   = 8'h00;
      out_ready   = 1'b0;
      wb_en       = 1'b0;
      wb_addr     = 3'd0;
      wb_data     = 8'h00;
      pc_load     = 1'b0;
      pc_load_val = 8'h00;
   endtask

   // Midway through ISSUE: asynchronous reset must clear outputs without a clock edge.
   task automatic reset_in_issue();
      drive_idle();
      #2 rst_n = 1'b0;
      #1;
      check("async_rst out_valid", {7'd0, out_valid}, 8'h00);
      check("async_rst mem_req", {7'd0, mem_req}, 8'h00);
      check("async_rst mem_addr", mem_addr, PCR);
      check("async_rst opcode", opcode, 8'h00);
      check("async_rst input1", input1, 8'h00);
      model_reset();
      @(negedge clk);
      rst_n    = 1'b1;
      rst_done = 1;
   endtask

   task automatic step();
      exp_t       e;
      bit         ack, wb, ld, rdy;
      logic [2:0] wa;
      logic [7:0] wd, lv;

      check("mem_req", {7'd0, mem_req}, {7'd0, (m_cnt < 4)});
      if (m_cnt < 4) check("mem_addr", mem_addr, m_pc);
      check("out_valid", {7'd0, out_valid}, {7'd0, (m_cnt == 4)});

      ack = (m_cnt < 4) && ($urandom_range(99) < ack_pct);
      wb  = ($urandom_range(99) < wb_pct);
      wa  = 3'($urandom);
      wd  = 8'($urandom);
      ld  = ($urandom_range(99) < load_pct);
      lv  = ($urandom_range(3) == 0) ? 8'hFC : 8'($urandom);
      rdy = ($urandom_range(99) < rdy_pct);

      mem_ack     = ack;
      mem_rdata   = ack ? mem[m_pc] : 8'($urandom);
      wb_en       = wb;
      wb_addr     = wa;
      wb_data     = wd;
      pc_load     = ld;
      pc_load_val = lv;
      out_ready   = rdy;

      if (ld) begin
         m_pc  = lv;
         m_cnt = 0;
      end else if (m_cnt < 4 && ack) begin
         m_bytes[m_cnt] = mem[m_pc];
         if (m_cnt == 3) begin
            e.op  = m_bytes[0];
            e.in1 = m_bytes[0][7] ? m_bytes[1] : reg_read(m_bytes[1], wb, wa, wd);
            e.in2 = m_bytes[0][6] ? m_bytes[2] : reg_read(m_bytes[2], wb, wa, wd);
            e.dst = m_bytes[3];
            sb.push_back(e);
         end
         m_pc  = m_pc + 8'd1;
         m_cnt = m_cnt + 1;
      end else if (m_cnt == 4 && rdy) begin
         m_cnt = 0;
      end

      if (wb && int'(wa) < int'(NR)) m_regs[wa] = wd;
   endtask

   // Monitor: compare presented operands against the scoreboard front.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (sb.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_issue: out_valid=1 expected no pending instruction");
            end else begin
               e = sb[0];
               check("opcode", opcode, e.op);
               check("input1", input1, e.in1);
               check("input2", input2, e.in2);
               check("dest", dest, e.dst);
               if (out_ready || pc_load) void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      mem[0] = 8'h00;
      mem[1] = 8'h05;
      mem[2] = 8'h03;
      mem[3] = 8'h02;
      mem[4] = 8'hC1;
      mem[5] = 8'h0A;
      mem[6] = 8'h03;
      mem[7] = 8'h11;

      rst_n = 1'b0;
      drive_idle();
      model_reset();
      repeat (3) @(negedge clk);
      check("reset mem_req", {7'd0, mem_req}, 8'h00);
      check("reset out_valid", {7'd0, out_valid}, 8'h00);
      check("reset opcode", opcode, 8'h00);
      check("reset input1", input1, 8'h00);
      check("reset input2", input2, 8'h00);
      check("reset dest", dest, 8'h00);
      check("reset mem_addr", mem_addr, PCR);
      rst_n = 1'b1;

      // Opening: back-to-back acks, no writebacks or redirects, heavy back-pressure.
      ack_pct  = 100;
      wb_pct   = 0;
      load_pct = 0;
      rdy_pct  = 20;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         if (cyc == 40) begin
            ack_pct  = 70;
            wb_pct   = 40;
            load_pct = 4;
            rdy_pct  = 50;
         end
         if (cyc >= 2000 && !rst_done && m_cnt == 4) reset_in_issue();
         else step();
      end

      drive_idle();
      if (!rst_done) begin
         vectors++;
         miscompares++;
         $display("FAIL reset_in_issue: ISSUE state never reached, got 0 expected 1");
      end
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
